// File: rtl/riscv_mem_pkg.sv
// Shared RV32 memory-access definitions: funct3 codes, request/pipeline types
// and the legality check used by the data memory.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // One slot of the response delay line; extension happens at the output end.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic        load;
        logic [1:0]  lane;
        logic [2:0]  funct3;
        logic [31:0] word;
    } rsp_stage_t;

    function automatic logic is_legal_access(input logic        we,
                                             input logic [2:0]  funct3,
                                             input logic [31:0] addr,
                                             input int unsigned depth);
        logic [32:0] limit;
        logic        ok;
        limit = 33'(depth) << 2;
        ok    = ({1'b0, addr} < limit);
        case (funct3)
            F3_B:    ok = ok;
            F3_H:    ok = ok && !addr[0];
            F3_W:    ok = ok && (addr[1:0] == 2'b00);
            F3_BU:   ok = ok && !we;
            F3_HU:   ok = ok && !we && !addr[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it
// according to the RV32 load funct3.
module dmem_load_extend
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[8*lane +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        data = '0;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_W:    data = word;
            F3_BU:   data = {24'b0, byte_sel};
            F3_HU:   data = {16'b0, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_sync.sv
// Byte-addressed synchronous data memory for the MEM stage: SB/SH/SW lane merges,
// sized loads with extension, error flagging and an RD_LAT-deep response pipeline.
module dmem_lsu_sync
    import riscv_mem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    RD_LAT      = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    mem_req_t    req;
    logic        accept;
    logic        legal;
    logic        do_store;
    logic        do_load;
    logic [AW-1:0] word_idx;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lanes;
    rsp_stage_t  stage_in;
    rsp_stage_t  pipe_q [RD_LAT];
    rsp_stage_t  rsp_q;
    logic [31:0] ext_data;

    assign req = '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) req_ready <= 1'b0;
        else     req_ready <= 1'b1;
    end

    assign accept   = req_valid && req_ready;
    assign legal    = is_legal_access(req.we, req.funct3, req.addr, DEPTH_WORDS);
    assign do_store = accept && legal && req.we;
    assign do_load  = accept && legal && !req.we;
    assign word_idx = req.addr[AW+1:2];

    // Replicate store data across lanes so each enabled lane picks the right bits.
    always_comb begin
        byte_en     = '0;
        wdata_lanes = req.wdata;
        case (req.funct3[1:0])
            2'b00: begin
                byte_en     = 4'b0001 << req.addr[1:0];
                wdata_lanes = {4{req.wdata[7:0]}};
            end
            2'b01: begin
                byte_en     = req.addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{req.wdata[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; contents survive rst and map onto block RAM.
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
            end
        end
    end

    always_comb begin
        stage_in        = '0;
        stage_in.valid  = accept;
        stage_in.err    = accept && !legal;
        stage_in.load   = do_load;
        stage_in.lane   = req.addr[1:0];
        stage_in.funct3 = req.funct3;
        stage_in.word   = do_load ? mem[word_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= stage_in;
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rsp_q = pipe_q[RD_LAT-1];

    dmem_load_extend u_extend (
        .word   (rsp_q.word),
        .lane   (rsp_q.lane),
        .funct3 (rsp_q.funct3),
        .data   (ext_data)
    );

    assign rsp_valid = rsp_q.valid;
    assign rsp_err   = rsp_q.err;
    assign rsp_rdata = (rsp_q.valid && rsp_q.load) ? ext_data : '0;

endmodule

// File: tb/tb_dmem_lsu_sync.sv
// Self-checking bench: two instances (RD_LAT=1 and 4) share stimulus and are checked
// every cycle against a byte-level memory model, plus literal expectations.
module tb_dmem_lsu_sync;
    import riscv_mem_pkg::*;

    localparam int DEPTH = 256;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        ready1, valid1, err1;
    logic [31:0] rdata1;
    logic        ready4, valid4, err4;
    logic [31:0] rdata4;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int vcount1     = 0;
    int vcount4     = 0;
    bit model_ready = 1'b0;

    bit [7:0] mem_m [int unsigned];
    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    bit   ev1, ev4;

    always #5 clk = ~clk;

    dmem_lsu_sync #(.DEPTH_WORDS(DEPTH), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid1), .rsp_rdata(rdata1), .rsp_err(err1)
    );

    dmem_lsu_sync #(.DEPTH_WORDS(DEPTH), .RD_LAT(4)) u_dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready4),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(valid4), .rsp_rdata(rdata4), .rsp_err(err4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Little-endian byte memory; sizes and signedness come straight from funct3.
    function automatic void model_eval(input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
        int     size;
        bit     sgn;
        longint val;
        size = 0;
        sgn  = 1'b0;
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: size = 4;
            3'b100: size = 1;
            3'b101: size = 2;
            default: size = 0;
        endcase
        err = (size == 0) || (we && f3[2]) || (longint'(addr) >= 4 * DEPTH);
        if (size != 0 && (addr % size) != 0) err = 1'b1;
        rdata = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mem_m[addr + i] = wdata[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val = val + (longint'(mem_m[addr + i]) << (8 * i));
                if (sgn && val[8*size-1]) val = val - (longint'(1) << (8 * size));
                rdata = val[31:0];
            end
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] m_rdata;
        logic        m_err;
        cyc++;
        if (rst) begin
            q1.delete();
            q4.delete();
            model_ready = 1'b0;
        end else begin
            if (req_valid && model_ready) begin
                model_eval(req_we, req_funct3, req_addr, req_wdata, m_rdata, m_err);
                q1.push_back('{due: cyc, rdata: m_rdata, err: m_err});
                q4.push_back('{due: cyc + 3, rdata: m_rdata, err: m_err});
            end
            model_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            ev1 = 1'b0;
            e1  = '{due: 0, rdata: 32'h0, err: 1'b0};
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e1  = q1.pop_front();
                ev1 = 1'b1;
            end
            ev4 = 1'b0;
            e4  = '{due: 0, rdata: 32'h0, err: 1'b0};
            if (q4.size() > 0 && q4[0].due == cyc) begin
                e4  = q4.pop_front();
                ev4 = 1'b1;
            end
            check("lat1_ready", {31'b0, ready1}, {31'b0, model_ready});
            check("lat1_valid", {31'b0, valid1}, {31'b0, ev1});
            check("lat1_rdata", rdata1, e1.rdata);
            check("lat1_err",   {31'b0, err1},   {31'b0, e1.err});
            check("lat4_ready", {31'b0, ready4}, {31'b0, model_ready});
            check("lat4_valid", {31'b0, valid4}, {31'b0, ev4});
            check("lat4_rdata", rdata4, e4.rdata);
            check("lat4_err",   {31'b0, err4},   {31'b0, e4.err});
            if (valid1 === 1'b1) vcount1++;
            if (valid4 === 1'b1) vcount4++;
        end
    end

    // Presents one request for one cycle; called and returns at 1 time unit after a rising edge.
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
    endtask

    task automatic check_req(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic exp_err);
        bit seen1, seen4;
        seen1 = 1'b0;
        seen4 = 1'b0;
        send(we, f3, addr, wdata);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (!seen1 && valid1 === 1'b1) begin
                seen1 = 1'b1;
                check({name, "_lat1_latency"}, n, 1);
                check({name, "_lat1_rdata"}, rdata1, exp_rdata);
                check({name, "_lat1_err"}, {31'b0, err1}, {31'b0, exp_err});
            end
            if (!seen4 && valid4 === 1'b1) begin
                seen4 = 1'b1;
                check({name, "_lat4_latency"}, n, 4);
                check({name, "_lat4_rdata"}, rdata4, exp_rdata);
                check({name, "_lat4_err"}, {31'b0, err4}, {31'b0, exp_err});
            end
        end
        if (!seen1) check({name, "_lat1_timeout"}, 0, 1);
        if (!seen4) check({name, "_lat4_timeout"}, 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c4;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;

        // Reset and release
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready1", {31'b0, ready1}, 32'd0);
        check("rst_valid4", {31'b0, valid4}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("release_ready_pre_edge", {31'b0, ready1}, 32'd0);
        @(posedge clk);
        #1;
        check("release_ready1", {31'b0, ready1}, 32'd1);
        check("release_ready4", {31'b0, ready4}, 32'd1);

        // Word store then load
        check_req("sw_10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        check_req("lw_10", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte merge and extension
        check_req("sb_13",  1'b1, F3_B,  32'h13, 32'h00000080, 32'h0, 1'b0);
        check_req("lb_13",  1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        check_req("lbu_13", 1'b0, F3_BU, 32'h13, 32'h0, 32'h00000080, 1'b0);
        check_req("lw_10b", 1'b0, F3_W,  32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

        // Halfword extension on the upper half
        check_req("sh_22",  1'b1, F3_H,  32'h22, 32'h00008001, 32'h0, 1'b0);
        check_req("lh_22",  1'b0, F3_H,  32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        check_req("lhu_22", 1'b0, F3_HU, 32'h22, 32'h0, 32'h00008001, 1'b0);

        // Error cases
        check_req("sh_11_mis",  1'b1, F3_H,   32'h11, 32'h00001234, 32'h0, 1'b1);
        check_req("lw_10c",     1'b0, F3_W,   32'h10, 32'h0, 32'h80ADBEEF, 1'b0);
        check_req("lw_02_mis",  1'b0, F3_W,   32'h02, 32'h0, 32'h0, 1'b1);
        check_req("f3_011",     1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        check_req("store_f3bu", 1'b1, F3_BU,  32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        check_req("lw_10d",     1'b0, F3_W,   32'h10, 32'h0, 32'h80ADBEEF, 1'b0);

        // Range
        check_req("sw_00",     1'b1, F3_W, 32'h0, 32'h0BADF00D, 32'h0, 1'b0);
        check_req("sw_oor",    1'b1, F3_W, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1);
        check_req("lw_oor",    1'b0, F3_W, 32'h400, 32'h0, 32'h0, 1'b1);
        check_req("lw_00",     1'b0, F3_W, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);

        // Back-to-back SW/LW/LW stream
        c1 = vcount1;
        c4 = vcount4;
        for (int k = 0; k < 4; k++) begin
            send(1'b1, F3_W, 32'h100 + 4 * k, 32'h11110000 + k);
            send(1'b0, F3_W, 32'h100 + 4 * k, 32'h0);
            send(1'b0, F3_W, 32'h10, 32'h0);
        end
        repeat (8) @(posedge clk);
        #1;
        check("stream_count_lat1", vcount1 - c1, 32'd12);
        check("stream_count_lat4", vcount4 - c4, 32'd12);

        // Reset with three loads in flight
        c1 = vcount1;
        c4 = vcount4;
        send(1'b0, F3_W, 32'h10, 32'h0);
        send(1'b0, F3_W, 32'h100, 32'h0);
        send(1'b0, F3_W, 32'h104, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // Request while req_ready is still low must be ignored
        send(1'b1, F3_W, 32'h10, 32'hFFFFFFFF);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_count_lat4", vcount4 - c4, 32'd0);
        check("midrst_count_lat1", vcount1 - c1, 32'd3);
        check_req("lw_10_post_rst",  1'b0, F3_W, 32'h10,  32'h0, 32'h80ADBEEF, 1'b0);
        check_req("lw_104_post_rst", 1'b0, F3_W, 32'h104, 32'h0, 32'h11110001, 1'b0);

        repeat (6) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
